mux_cfg_loader: RTL and testbench
=================================

MUX_CFG_LOADER -- requirements
Module: mux_cfg_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 40, meaning total configuration-chain length in bits (sram bits of all routing muxes in the chain), legal range 1..65535.
REQ-002 SHALL have parameter WORD_W, default 8, meaning bitstream word width, legal range 2..32.
REQ-003 SHALL have port prog_clk  input  1  sole clock; all flops rising-edge.
REQ-004 SHALL have port prog_reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  begin a load; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  terminate any load immediately.
REQ-007 SHALL have port bs_data  input  WORD_W  bitstream word; MSB shifted first.
REQ-008 SHALL have port bs_valid  input  1  bs_data valid.
REQ-009 SHALL have port bs_ready  output  1  loader accepts a word this cycle.
REQ-010 SHALL have port ccff_head  output  1  serial bit to the config-chain head.
REQ-011 SHALL have port prog_en  output  1  chain shift enable; one bit enters the chain on each edge where prog_en=1.
REQ-012 SHALL have port ccff_tail  input  1  serial bit from the config-chain tail.
REQ-013 SHALL have port busy  output  1  load in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse on load completion.
REQ-015 SHALL have port rb_data  output  WORD_W  readback word.
REQ-016 SHALL have port rb_valid  output  1  one-cycle rb_data strobe.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_WORD, SHIFT, DONE.
REQ-018 SHALL, in IDLE, transition to WAIT_WORD on start=1 and clear the bit counter to 0.
REQ-019 SHALL drive bs_ready=1 only in WAIT_WORD; a word is accepted on the edge where bs_valid and bs_ready are both 1 and is loaded into the shift register, with the FSM moving to SHIFT.
REQ-020 SHALL, in SHIFT, drive prog_en=1 and ccff_head=shift-register MSB, shift left by one, and increment the bit counter each cycle.
REQ-021 SHALL leave SHIFT after WORD_W bits or when the bit counter reaches CHAIN_LEN, whichever comes first; the FSM goes to DONE if CHAIN_LEN is reached, else to WAIT_WORD.
REQ-022 SHALL discard the unused low bits of the final word when CHAIN_LEN is not a multiple of WORD_W.
REQ-023 SHALL assert prog_en for exactly CHAIN_LEN cycles per completed load.
REQ-024 SHALL, in DONE, pulse done=1 for one cycle, then return to IDLE.
REQ-025 SHALL drive busy=1 in WAIT_WORD and SHIFT only.
REQ-026 SHALL drive ccff_head=0 and prog_en=0 outside SHIFT.
REQ-027 SHALL derive all outputs from registers only, with no combinational input-to-output path.
REQ-028 SHALL, on abort=1 in any state, go to IDLE on the next edge without asserting done; abort SHALL win over start and over a simultaneous word handshake.
REQ-029 SHALL ignore start outside IDLE.
REQ-030 SHALL hold state in WAIT_WORD indefinitely while bs_valid=0, with prog_en=0.

Reset
REQ-031 SHALL, while prog_reset_n=0, asynchronously force state=IDLE, counter=0, shift registers=0, and bs_ready, ccff_head, prog_en, busy, done, rb_data and rb_valid all 0.
REQ-032 SHALL treat reset mid-load as abandoning the load; no done is issued, and the next load restarts from bit 0.

Configuration
REQ-033 SHALL use macro MUX_CFG_READBACK_EN; when defined, each SHIFT cycle SHALL capture ccff_tail MSB-first into a readback register.
REQ-034 SHALL, when MUX_CFG_READBACK_EN is defined, pulse rb_valid for one cycle after WORD_W captured bits or at CHAIN_LEN; a partial final word is left-aligned with low bits zero.
REQ-035 SHALL, when MUX_CFG_READBACK_EN is undefined, keep the rb_data and rb_valid ports present, tie them to 0, and instantiate no readback flops.

Verification
REQ-036 SHALL cover: CHAIN_LEN=40, WORD_W=8, 5 words 0xA5,0x3C,0xFF,0x00,0x81 offered back-to-back -> ccff_head bit sequence matches MSB-first, prog_en high 40 cycles, one done pulse.
REQ-037 SHALL cover: CHAIN_LEN=13, WORD_W=8, words 0xF0,0xAB -> 13 shift cycles; bits 10101 of 0xAB sent, 011 discarded; done pulse.
REQ-038 SHALL cover: bs_valid low 20 cycles between words -> prog_en=0 throughout the gap; bit stream unchanged.
REQ-039 SHALL cover: abort on 3rd SHIFT cycle of word 2 -> IDLE next cycle, done never asserted, restart sends from bit 0.
REQ-040 SHALL cover: prog_reset_n low mid-SHIFT -> all outputs 0 immediately (asynchronously); start in same cycle as abort in IDLE -> stays IDLE.
REQ-041 SHALL cover: MUX_CFG_READBACK_EN defined, a 40-bit chain preloaded with a known pattern -> rb_data sequence equals the old chain contents across 5 rb_valid pulses.

Source files
------------

// File: rtl/mux_cfg_loader.sv
// Configuration-chain loader: streams bitstream words MSB-first into a routing-mux config chain.
// Define MUX_CFG_READBACK_EN to capture the old chain contents from ccff_tail into rb_data/rb_valid.
`timescale 1ns/1ps
module mux_cfg_loader #(
  parameter int CHAIN_LEN = 40,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              prog_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic              last_in_word;
  logic              chain_end;

  // Word handshake: bs_ready is high only in WAIT; a word transfers on any edge
  // where bs_valid && bs_ready, unless abort is high on that same edge.
  assign last_in_word = (bit_q == LAST_BIT);
  assign chain_end    = (cnt_q == LAST_CNT);

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_WAIT;
        S_WAIT:  if (bs_valid) state_d = S_SHIFT;
        S_SHIFT: begin
          if (chain_end)         state_d = S_DONE;
          else if (last_in_word) state_d = S_WAIT;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    sreg_d = sreg_q;
    case (state_q)
      S_IDLE: if (start) cnt_d = '0;
      S_WAIT: begin
        if (bs_valid && !abort) begin
          sreg_d = bs_data;
          bit_d  = '0;
        end
      end
      S_SHIFT: begin
        sreg_d = {sreg_q[WORD_W-2:0], 1'b0};
        cnt_d  = cnt_q + 1'b1;
        bit_d  = bit_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    bs_ready  = (state_q == S_WAIT);
    busy      = (state_q == S_WAIT) || (state_q == S_SHIFT);
    prog_en   = (state_q == S_SHIFT);
    ccff_head = (state_q == S_SHIFT) ? sreg_q[WORD_W-1] : 1'b0;
    done      = (state_q == S_DONE);
    dbg_state = state_q;
  end

`ifdef MUX_CFG_READBACK_EN
  logic [WORD_W-1:0] rb_sreg_q, rb_sreg_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;
  logic [WORD_W-1:0] rb_cap;

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      rb_sreg_q  <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_sreg_q  <= rb_sreg_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  // The capture register restarts from zero per word, so a short final word
  // only needs a left shift to become left-aligned with zero low bits.
  always_comb begin
    rb_sreg_d  = rb_sreg_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    rb_cap     = {rb_sreg_q[WORD_W-2:0], ccff_tail};
    if (state_q == S_IDLE && start) begin
      rb_sreg_d = '0;
    end else if (state_q == S_SHIFT) begin
      rb_sreg_d = rb_cap;
      if (last_in_word || chain_end) begin
        rb_sreg_d  = '0;
        rb_data_d  = rb_cap << (LAST_BIT - bit_q);
        rb_valid_d = !abort;
      end
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign rb_data     = '0;
  assign rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_mux_cfg_loader.sv
// Bench for mux_cfg_loader: a 40-bit and a 13-bit instance behind a shared driver, checked
// against bitstream/chain models. Readback checks are active when MUX_CFG_READBACK_EN is defined.
`timescale 1ns/1ps
module tb_mux_cfg_loader;
  localparam int LA = 40;
  localparam int LB = 13;
  localparam int W  = 8;

  // ---------------- clock / reset ----------------
  logic prog_clk = 1'b0;
  logic prog_reset_n;
  always #5 prog_clk = ~prog_clk;

  // sel chooses which instance the driver and monitors talk to (0: 40-bit, 1: 13-bit)
  logic         sel;
  logic         start, abort, bs_valid, pre_load;
  logic [W-1:0] bs_data;

  logic a_ready, a_head, a_pe, a_tail, a_busy, a_done, a_rbv;
  logic b_ready, b_head, b_pe, b_tail, b_busy, b_done, b_rbv;
  logic [W-1:0] a_rbd, b_rbd;
  logic [1:0]   a_st, b_st;

  mux_cfg_loader #(.CHAIN_LEN(LA), .WORD_W(W)) dut_a (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n),
    .start(start & ~sel), .abort(abort & ~sel),
    .bs_data(bs_data), .bs_valid(bs_valid & ~sel), .bs_ready(a_ready),
    .ccff_head(a_head), .prog_en(a_pe), .ccff_tail(a_tail),
    .busy(a_busy), .done(a_done), .rb_data(a_rbd), .rb_valid(a_rbv), .dbg_state(a_st)
  );

  mux_cfg_loader #(.CHAIN_LEN(LB), .WORD_W(W)) dut_b (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n),
    .start(start & sel), .abort(abort & sel),
    .bs_data(bs_data), .bs_valid(bs_valid & sel), .bs_ready(b_ready),
    .ccff_head(b_head), .prog_en(b_pe), .ccff_tail(b_tail),
    .busy(b_busy), .done(b_done), .rb_data(b_rbd), .rb_valid(b_rbv), .dbg_state(b_st)
  );

  logic c_ready, c_head, c_pe, c_busy, c_done, c_rbv;
  logic [W-1:0] c_rbd;
  logic [1:0]   c_st;
  assign c_ready = sel ? b_ready : a_ready;
  assign c_head  = sel ? b_head  : a_head;
  assign c_pe    = sel ? b_pe    : a_pe;
  assign c_busy  = sel ? b_busy  : a_busy;
  assign c_done  = sel ? b_done  : a_done;
  assign c_rbv   = sel ? b_rbv   : a_rbv;
  assign c_rbd   = sel ? b_rbd   : a_rbd;
  assign c_st    = sel ? b_st    : a_st;

  // Config chains: bit 0 is the head, the top bit drives ccff_tail.
  localparam logic [LA-1:0] PRE_A = 40'hC35A0FE196;
  localparam logic [LB-1:0] PRE_B = 13'h1A5C;
  logic [LA-1:0] chain_a;
  logic [LB-1:0] chain_b;
  assign a_tail = chain_a[LA-1];
  assign b_tail = chain_b[LB-1];
  always @(posedge prog_clk) begin
    if (pre_load) begin
      chain_a <= PRE_A;
      chain_b <= PRE_B;
    end else begin
      if (a_pe) chain_a <= {chain_a[LA-2:0], a_head};
      if (b_pe) chain_b <= {chain_b[LB-2:0], b_head};
    end
  end

  // ---------------- monitors ----------------
  logic         got_q[$];
  logic [W-1:0] rb_got_q[$];
  int           done_cnt = 0;
  int           rb_stray = 0;
  always @(negedge prog_clk) begin
    if (c_pe) got_q.push_back(c_head);
    if (c_done) done_cnt++;
    if (c_rbv) rb_got_q.push_back(c_rbd);
    if (c_rbv || c_rbd != '0) rb_stray++;
  end

  // ---------------- scoreboard ----------------
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] wq[$];
  logic         exp_bits_q[$];
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected chain-head stream: words concatenated MSB-first, cut at the chain length.
  function automatic void build_exp(input int len);
    exp_bits_q.delete();
    for (int k = 0; k < len; k++) exp_bits_q.push_back(wq[k / W][W - 1 - (k % W)]);
  endfunction

  // Expected readback: old chain contents leaving the tail, grouped into words, last word left-aligned.
  function automatic void build_rb_exp(input logic [LA-1:0] snap, input int len);
    logic [W-1:0] w;
    exp_q.delete();
    w = '0;
    for (int k = 0; k < len; k++) begin
      w[W - 1 - (k % W)] = snap[len - 1 - k];
      if ((k % W) == W - 1 || k == len - 1) begin
        exp_q.push_back(w);
        w = '0;
      end
    end
  endfunction

  task automatic check_idle(input string name);
    check({name, " flags"}, {c_busy, c_ready, c_pe, c_head, c_done, c_rbv}, 6'b0);
    check({name, " rb_data"}, c_rbd, 0);
    check({name, " state idle"}, c_st, 0);
  endtask

  // ---------------- driver ----------------
  task automatic wait_ready(input bit noise, inout bit tmo);
    int n;
    n = 0;
    while (!c_ready && n < 100) begin
      if (noise) start = 1'($urandom_range(0, 1));
      @(negedge prog_clk);
      n++;
    end
    if (n >= 100) tmo = 1'b1;
  endtask

  task automatic run_load(input int gap, input bit noise, output int gap_pe, output bit tmo);
    int n;
    gap_pe = 0;
    tmo = 1'b0;
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    for (int i = 0; i < wq.size(); i++) begin
      if (gap > 0 && i > 0) begin
        wait_ready(noise, tmo);
        start = 1'b0;
        repeat (gap) begin
          @(negedge prog_clk);
          if (c_pe || !c_ready) gap_pe++;
        end
      end
      bs_data  = wq[i];
      bs_valid = 1'b1;
      wait_ready(noise, tmo);
      @(negedge prog_clk);
      bs_valid = 1'b0;
      start    = 1'b0;
    end
    n = 0;
    while (c_busy && n < 100) begin
      @(negedge prog_clk);
      n++;
    end
    if (n >= 100) tmo = 1'b1;
    repeat (2) @(negedge prog_clk);
  endtask

  task automatic load_and_check(input string name, input int gap, input bit noise, input int done_base,
                                input bit use_const, input logic [LA-1:0] const_bits);
    logic [LA-1:0] snap, got_val;
    int len, gap_pe, bad, rb_base;
    bit tmo;
    len = sel ? LB : LA;
    snap = sel ? LA'(chain_b) : chain_a;
    got_q.delete();
    rb_got_q.delete();
    rb_base = rb_stray;
    build_exp(len);
    run_load(gap, noise, gap_pe, tmo);
    check({name, " timeout"}, tmo, 0);
    check({name, " prog_en cycles"}, got_q.size(), len);
    bad = 0;
    for (int k = 0; k < len; k++)
      if (k >= got_q.size() || got_q[k] !== exp_bits_q[k]) bad++;
    check({name, " bad stream bits"}, bad, 0);
    if (use_const) begin
      got_val = '0;
      foreach (got_q[k]) got_val = {got_val[LA-2:0], got_q[k]};
      check({name, " stream value"}, got_val, const_bits);
    end
    check({name, " done pulses"}, done_cnt - done_base, 1);
    check({name, " prog_en in gap"}, gap_pe, 0);
`ifdef MUX_CFG_READBACK_EN
    build_rb_exp(snap, len);
    check({name, " rb pulses"}, rb_got_q.size(), exp_q.size());
    bad = 0;
    for (int k = 0; k < exp_q.size(); k++)
      if (k >= rb_got_q.size() || rb_got_q[k] !== exp_q[k]) bad++;
    check({name, " bad rb words"}, bad, 0);
`else
    check({name, " rb tied low"}, rb_stray - rb_base, 0);
`endif
  endtask

  task automatic random_words(input int len);
    wq.delete();
    for (int i = 0; i < (len + W - 1) / W; i++) wq.push_back(W'($urandom_range(0, 255)));
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic          sel;
    int            n_words;
    logic [5*W-1:0] words;
    int            gap;
    logic [LA-1:0] exp_bits;
  } vec_t;
  vec_t tv[4];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    tv[0] = '{1'b0, 5, 40'hA53CFF0081, 0,  40'hA53CFF0081};
    tv[1] = '{1'b1, 2, 40'hF0AB000000, 0,  40'h0000001E15};
    tv[2] = '{1'b0, 5, 40'h123456789A, 20, 40'h123456789A};
    tv[3] = '{1'b1, 2, 40'h0F5F000000, 20, 40'h00000001EB};

    sel = 1'b0; start = 1'b0; abort = 1'b0; bs_valid = 1'b0; bs_data = '0;
    pre_load = 1'b1;
    prog_reset_n = 1'b0;
    repeat (3) @(negedge prog_clk);
    check_idle("reset a");
    sel = 1'b1;
    #1 check_idle("reset b");
    sel = 1'b0;
    prog_reset_n = 1'b1;
    pre_load = 1'b0;
    @(negedge prog_clk);
    check_idle("after reset");

    // directed table
    for (int t = 0; t < 4; t++) begin
      sel = tv[t].sel;
      wq.delete();
      for (int i = 0; i < tv[t].n_words; i++) wq.push_back(tv[t].words[(4 - i) * W +: W]);
      load_and_check($sformatf("vec%0d", t), tv[t].gap, 1'b0, done_cnt, 1'b1, tv[t].exp_bits);
    end

    // start together with abort in IDLE
    sel = 1'b0;
    start = 1'b1; abort = 1'b1;
    @(negedge prog_clk);
    start = 1'b0; abort = 1'b0;
    check("start+abort state", c_st, 0);
    check("start+abort busy", c_busy, 0);

    // abort beats a simultaneous word handshake
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    got_q.delete();
    bs_data = 8'hFF; bs_valid = 1'b1; abort = 1'b1;
    @(negedge prog_clk);
    bs_valid = 1'b0; abort = 1'b0;
    @(negedge prog_clk);
    check("abort vs handshake state", c_st, 0);
    check("abort vs handshake shifts", got_q.size(), 0);

    // abort on the third shift cycle of word 2, then restart
    base = done_cnt;
    got_q.delete();
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    bs_data = 8'h12; bs_valid = 1'b1;
    @(negedge prog_clk);
    bs_valid = 1'b0;
    n = 0;
    while (!c_ready && n < 50) begin
      @(negedge prog_clk);
      n++;
    end
    check("abort word1 wait", n < 50, 1);
    bs_data = 8'h34; bs_valid = 1'b1;
    @(negedge prog_clk);
    bs_valid = 1'b0;
    repeat (2) @(negedge prog_clk);
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    check("abort state", c_st, 0);
    check("abort busy/prog_en", {c_busy, c_pe}, 2'b00);
    check("abort shifts", got_q.size(), 11);
    begin
      logic [LA-1:0] v;
      v = '0;
      foreach (got_q[k]) v = {v[LA-2:0], got_q[k]};
      check("abort partial stream", v, 40'h091);
    end
    repeat (3) @(negedge prog_clk);
    check("abort no done", done_cnt - base, 0);
    random_words(LA);
    load_and_check("restart after abort", 0, 1'b0, base, 1'b0, '0);

    // asynchronous reset in the middle of SHIFT
    base = done_cnt;
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    bs_data = 8'hFF; bs_valid = 1'b1;
    @(negedge prog_clk);
    bs_valid = 1'b0;
    @(negedge prog_clk);
    check("pre-reset prog_en", c_pe, 1);
    #2 prog_reset_n = 1'b0;
    #1 check_idle("async reset");
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
    @(negedge prog_clk);
    check("reset no done", done_cnt - base, 0);
    random_words(LA);
    load_and_check("restart after reset", 0, 1'b0, base, 1'b0, '0);

    // randomized loads with gaps and stray start pulses
    for (int it = 0; it < 10; it++) begin
      sel = 1'(it % 2);
      random_words(sel ? LB : LA);
      load_and_check($sformatf("rand%0d", it), $urandom_range(0, 4), 1'b1, done_cnt, 1'b0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
